// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// ID-stage instruction decoder for the RV32IM five-stage pipeline.
// The decode is purely combinational. A startup flag, cleared asynchronously by
// RESET and set on the first rising CLK edge after RESET is released, forces a
// bubble until the pipeline has taken at least one clock edge.
//
// Ports
//   CLK          in   1  pipeline clock (rising edge sets the startup flag)
//   RESET        in   1  asynchronous, active-high; clears the startup flag
//   INSTRUCTION  in  32  instruction word from IF/ID
//   ALUOP        out  5  {M, alt, funct3}; {11,funct3} for branch compares,
//                        11010 passes operand B (LUI)
//   IMME_SELECT  out  3  001 U, 010 I, 011 S, 100 B, 101 J, 110 I-shift
//   MUX1_SELECT  out  1  ALU operand A: 0 rs1, 1 PC
//   MUX2_SELECT  out  1  ALU operand B: 0 immediate, 1 rs2
//   MUX3_SELECT  out  2  write-back: 00 memory, 01 ALU, 10 PC+4
//   MUX4_SELECT  out  1  jump/branch target: 0 PC+imm, 1 ALU result
//   MEMREAD      out  1  data-memory read enable
//   MEMWRITE     out  1  data-memory write enable
//   BRANCH       out  1  conditional branch
//   JUMP         out  1  unconditional jump
//   WRITEENABLE  out  1  register-file write enable
// -----------------------------------------------------------------------------
module control_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   output logic [4:0]  ALUOP,
   output logic [2:0]  IMME_SELECT,
   output logic        MUX1_SELECT,
   output logic        MUX2_SELECT,
   output logic [1:0]  MUX3_SELECT,
   output logic        MUX4_SELECT,
   output logic        MEMREAD,
   output logic        MEMWRITE,
   output logic        BRANCH,
   output logic        JUMP,
   output logic        WRITEENABLE
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_U  = 3'b001;
   localparam logic [2:0] IMM_I  = 3'b010;
   localparam logic [2:0] IMM_S  = 3'b011;
   localparam logic [2:0] IMM_B  = 3'b100;
   localparam logic [2:0] IMM_J  = 3'b101;
   localparam logic [2:0] IMM_SH = 3'b110;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_PASSB = 5'b11010;

   logic       started;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = INSTRUCTION[6:0];
   assign funct3 = INSTRUCTION[14:12];
   assign funct7 = INSTRUCTION[31:25];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) started <= 1'b0;
      else       started <= 1'b1;
   end

   // Enables default to 0 so a bubble never leaks a side effect; selects and
   // ALUOP default to X so synthesis may pick whatever is cheapest.
   always_comb begin
      ALUOP       = 'x;
      IMME_SELECT = 'x;
      MUX1_SELECT = 1'bx;
      MUX2_SELECT = 1'bx;
      MUX3_SELECT = 'x;
      MUX4_SELECT = 1'bx;
      MEMREAD     = 1'b0;
      MEMWRITE    = 1'b0;
      BRANCH      = 1'b0;
      JUMP        = 1'b0;
      WRITEENABLE = 1'b0;

      if (started && !RESET) begin
         unique case (opcode)
            OP_R: begin
               if (funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                   funct7 == 7'b0000001) begin
                  ALUOP       = {funct7[0], funct7[5], funct3};
                  MUX1_SELECT = 1'b0;
                  MUX2_SELECT = 1'b1;
                  MUX3_SELECT = WB_ALU;
                  MUX4_SELECT = 1'b0;
                  WRITEENABLE = 1'b1;
               end
            end
            OP_IMM: begin
               // Only SRAI uses funct7[5]; for other funct3 that bit is
               // ordinary immediate data (e.g. a negative ADDI).
               ALUOP       = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
               IMME_SELECT = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
               MUX1_SELECT = 1'b0;
               MUX2_SELECT = 1'b0;
               MUX3_SELECT = WB_ALU;
               MUX4_SELECT = 1'b0;
               WRITEENABLE = 1'b1;
            end
            OP_LOAD: begin
               ALUOP       = ALU_ADD;
               IMME_SELECT = IMM_I;
               MUX1_SELECT = 1'b0;
               MUX2_SELECT = 1'b0;
               MUX3_SELECT = WB_MEM;
               MUX4_SELECT = 1'b0;
               MEMREAD     = 1'b1;
               WRITEENABLE = 1'b1;
            end
            OP_STORE: begin
               ALUOP       = ALU_ADD;
               IMME_SELECT = IMM_S;
               MUX1_SELECT = 1'b0;
               MUX2_SELECT = 1'b0;
               MUX4_SELECT = 1'b0;
               MEMWRITE    = 1'b1;
            end
            OP_BRANCH: begin
               ALUOP       = {2'b11, funct3};
               IMME_SELECT = IMM_B;
               MUX1_SELECT = 1'b0;
               MUX2_SELECT = 1'b1;
               MUX4_SELECT = 1'b0;
               BRANCH      = 1'b1;
            end
            OP_JAL: begin
               IMME_SELECT = IMM_J;
               MUX3_SELECT = WB_PC4;
               MUX4_SELECT = 1'b0;
               JUMP        = 1'b1;
               WRITEENABLE = 1'b1;
            end
            OP_JALR: begin
               if (funct3 == 3'b000) begin
                  ALUOP       = ALU_ADD;
                  IMME_SELECT = IMM_I;
                  MUX1_SELECT = 1'b0;
                  MUX2_SELECT = 1'b0;
                  MUX3_SELECT = WB_PC4;
                  MUX4_SELECT = 1'b1;
                  JUMP        = 1'b1;
                  WRITEENABLE = 1'b1;
               end
            end
            OP_LUI: begin
               ALUOP       = ALU_PASSB;
               IMME_SELECT = IMM_U;
               MUX2_SELECT = 1'b0;
               MUX3_SELECT = WB_ALU;
               MUX4_SELECT = 1'b0;
               WRITEENABLE = 1'b1;
            end
            OP_AUIPC: begin
               ALUOP       = ALU_ADD;
               IMME_SELECT = IMM_U;
               MUX1_SELECT = 1'b1;
               MUX2_SELECT = 1'b0;
               MUX3_SELECT = WB_ALU;
               MUX4_SELECT = 1'b0;
               WRITEENABLE = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed-vector bench for control_unit. All outputs are packed into one
// 18-bit word; each vector carries a hand-computed expected word and a care
// mask that excludes the don't-care fields.
// Packing: ALUOP[17:13] IMME[12:10] M1[9] M2[8] M3[7:6] M4[5]
//          MEMREAD[4] MEMWRITE[3] BRANCH[2] JUMP[1] WRITEENABLE[0]
// -----------------------------------------------------------------------------
module tb_control_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic [4:0]  ALUOP;
   logic [2:0]  IMME_SELECT;
   logic        MUX1_SELECT, MUX2_SELECT, MUX4_SELECT;
   logic [1:0]  MUX3_SELECT;
   logic        MEMREAD, MEMWRITE, BRANCH, JUMP, WRITEENABLE;

   control_unit dut (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
      .ALUOP(ALUOP), .IMME_SELECT(IMME_SELECT),
      .MUX1_SELECT(MUX1_SELECT), .MUX2_SELECT(MUX2_SELECT),
      .MUX3_SELECT(MUX3_SELECT), .MUX4_SELECT(MUX4_SELECT),
      .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .BRANCH(BRANCH),
      .JUMP(JUMP), .WRITEENABLE(WRITEENABLE)
   );

   always #5 CLK = ~CLK;

   logic [17:0] obs;
   assign obs = {ALUOP, IMME_SELECT, MUX1_SELECT, MUX2_SELECT, MUX3_SELECT,
                 MUX4_SELECT, MEMREAD, MEMWRITE, BRANCH, JUMP, WRITEENABLE};

   // care masks
   localparam logic [17:0] C_ALL = 18'h3FFFF;
   localparam logic [17:0] C_BUB = 18'h0001F; // enables only
   localparam logic [17:0] C_R   = 18'h3E3FF; // IMME don't-care
   localparam logic [17:0] C_SB  = 18'h3FF3F; // MUX3 don't-care
   localparam logic [17:0] C_JAL = 18'h01CFF; // ALUOP, MUX1, MUX2 don't-care
   localparam logic [17:0] C_LUI = 18'h3FDFF; // MUX1 don't-care

   int n_vec = 0;
   int n_err = 0;

   // en = {MEMREAD, MEMWRITE, BRANCH, JUMP, WRITEENABLE}
   function automatic logic [17:0] mk(input logic [4:0] aop, input logic [2:0] imm,
                                      input logic m1, input logic m2,
                                      input logic [1:0] m3, input logic m4,
                                      input logic [4:0] en);
      return {aop, imm, m1, m2, m3, m4, en};
   endfunction

   task automatic chk(input string tag, input logic [31:0] instr,
                      input logic [17:0] exp, input logic [17:0] care);
      INSTRUCTION = instr;
      #1;
      n_vec++;
      assert ((obs & care) === (exp & care)) else begin
         n_err++;
         $error("FAIL %s: instr %h observed %h required %h (care %h)",
                tag, instr, obs & care, exp & care, care);
      end
   endtask

   localparam logic [17:0] BUB = 18'h0;

   initial begin
      RESET = 1'b1;
      INSTRUCTION = 32'h01308433;
      #2;
      chk("reset_add", 32'h01308433, BUB, C_BUB);
      @(posedge CLK);
      #1;
      chk("reset_held_edge", 32'h01308433, BUB, C_BUB);
      @(negedge CLK);
      RESET = 1'b0;
      chk("released_no_edge", 32'h01308433, BUB, C_BUB);
      @(posedge CLK);
      #1;
      chk("add", 32'h01308433, mk(5'b00000, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);
      chk("zero_word", 32'h00000000, BUB, C_BUB);
      chk("addi", 32'h00000513, mk(5'b00000, 3'b010, 0, 0, 2'b01, 0, 5'b00001), C_ALL);
      chk("addi_bit30", 32'h40000093, mk(5'b00000, 3'b010, 0, 0, 2'b01, 0, 5'b00001), C_ALL);
      chk("slli", 32'h00109093, mk(5'b00001, 3'b110, 0, 0, 2'b01, 0, 5'b00001), C_ALL);
      chk("srai", 32'h40115093, mk(5'b01101, 3'b110, 0, 0, 2'b01, 0, 5'b00001), C_ALL);
      chk("sw", 32'h00A12223, mk(5'b00000, 3'b011, 0, 0, 2'b00, 0, 5'b01000), C_SB);
      chk("lw", 32'h00012503, mk(5'b00000, 3'b010, 0, 0, 2'b00, 0, 5'b10001), C_ALL);
      chk("beq", 32'h00B50463, mk(5'b11000, 3'b100, 0, 1, 2'b00, 0, 5'b00100), C_SB);
      chk("bne", 32'h00B51463, mk(5'b11001, 3'b100, 0, 1, 2'b00, 0, 5'b00100), C_SB);
      chk("jalr", 32'h000080E7, mk(5'b00000, 3'b010, 0, 0, 2'b10, 1, 5'b00011), C_ALL);
      chk("jalr_bad_f3", 32'h000090E7, BUB, C_BUB);
      chk("jal", 32'h008000EF, mk(5'b00000, 3'b101, 0, 0, 2'b10, 0, 5'b00011), C_JAL);
      chk("lui", 32'h123450B7, mk(5'b11010, 3'b001, 0, 0, 2'b01, 0, 5'b00001), C_LUI);
      chk("auipc", 32'h00001097, mk(5'b00000, 3'b001, 1, 0, 2'b01, 0, 5'b00001), C_ALL);
      chk("mul", 32'h02B50533, mk(5'b10000, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);
      chk("remu", 32'h0220F0B3, mk(5'b10111, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);
      chk("sub", 32'h40000033, mk(5'b01000, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);
      chk("sra", 32'h403150B3, mk(5'b01101, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);
      chk("bad_funct7", 32'h80000033, BUB, C_BUB);
      chk("bad_opcode", 32'h0000007F, BUB, C_BUB);

      // reset mid-operation: bubble at once, and stays until the next edge
      chk("live_before_rst", 32'h00012503, mk(5'b00000, 3'b010, 0, 0, 2'b00, 0, 5'b10001), C_ALL);
      @(negedge CLK);
      RESET = 1'b1;
      chk("mid_reset", 32'h00012503, BUB, C_BUB);
      RESET = 1'b0;
      chk("post_reset_no_edge", 32'h01308433, BUB, C_BUB);
      @(posedge CLK);
      #1;
      chk("post_reset_live", 32'h01308433, mk(5'b00000, 3'b000, 0, 1, 2'b01, 0, 5'b00001), C_R);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
